rf_cmd_ctrl: RTL and testbench



---
 rtl/rf_cmd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rf_cmd_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_cmd_ctrl.sv
// Byte-stream command sequencer: turns 0xAA (write) / 0xBB (read) frames into
// register-file transactions and forwards read data to the TX FIFO.
module rf_cmd_ctrl #(
    parameter  int WIDTH      = 8,
    parameter  int DEPTH      = 16,
    parameter  int RD_TIMEOUT = 4,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  RX_P_DATA,
    input  logic              RX_D_VLD,
    output logic              RF_WrEn,
    output logic              RF_RdEn,
    output logic [ADDR_W-1:0] RF_Address,
    output logic [WIDTH-1:0]  RF_WrData,
    input  logic [WIDTH-1:0]  RF_RdData,
    input  logic              RF_RdData_Valid,
    output logic [WIDTH-1:0]  TX_P_DATA,
    output logic              TX_D_VLD,
    input  logic              TX_FULL,
    output logic              BUSY,
    output logic              CMD_ERR
);

    localparam int               CNT_W  = $clog2(RD_TIMEOUT + 1);
    localparam logic [WIDTH-1:0] CMD_WR = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0] CMD_RD = WIDTH'(8'hBB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_EXEC,
        S_RD_ADDR,
        S_RD_EXEC,
        S_RD_WAIT,
        S_TX_SEND
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_cmd_err;
    logic                r_wr_en;
    logic                r_rd_en;
    logic                r_tx_vld;
    logic [ADDR_W-1:0]   r_addr;
    logic [WIDTH-1:0]    r_wr_data;
    logic [WIDTH-1:0]    r_tx_data;
    logic [CNT_W-1:0]    r_to_cnt;

    logic                w_addr_ok;
    logic [ADDR_W-1:0]   w_addr;

    // An address byte is legal only if every bit above the RF index is clear.
    assign w_addr_ok = ((RX_P_DATA >> ADDR_W) == '0);
    assign w_addr    = RX_P_DATA[ADDR_W-1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_cmd_err <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_tx_vld  <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_tx_data <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_cmd_err <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_tx_vld  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == CMD_WR) begin
                            r_state <= S_WR_ADDR;
                            r_busy  <= 1'b1;
                        end else if (RX_P_DATA == CMD_RD) begin
                            r_state <= S_RD_ADDR;
                            r_busy  <= 1'b1;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                end
                S_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        if (w_addr_ok) begin
                            r_addr  <= w_addr;
                            r_state <= S_WR_DATA;
                        end else begin
                            r_cmd_err <= 1'b1;
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                        end
                    end
                end
                S_WR_DATA: begin
                    // Strobe is raised on the capture edge so the write lands one cycle after the byte.
                    if (RX_D_VLD) begin
                        r_wr_data <= RX_P_DATA;
                        r_wr_en   <= 1'b1;
                        r_state   <= S_WR_EXEC;
                    end
                end
                S_WR_EXEC: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        if (w_addr_ok) begin
                            r_addr  <= w_addr;
                            r_rd_en <= 1'b1;
                            r_state <= S_RD_EXEC;
                        end else begin
                            r_cmd_err <= 1'b1;
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                        end
                    end
                end
                S_RD_EXEC: begin
                    r_to_cnt <= '0;
                    r_state  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // Emitting straight from here saves a cycle when the FIFO has room.
                    if (RF_RdData_Valid) begin
                        r_tx_data <= RF_RdData;
                        r_tx_vld  <= ~TX_FULL;
                        r_state   <= S_TX_SEND;
                    end else if (r_to_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                        r_cmd_err <= 1'b1;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + CNT_W'(1);
                    end
                end
                S_TX_SEND: begin
                    if (r_tx_vld) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!TX_FULL) begin
                        r_tx_vld <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign RF_WrEn    = r_wr_en;
    assign RF_RdEn    = r_rd_en;
    assign RF_Address = r_addr;
    assign RF_WrData  = r_wr_data;
    assign TX_P_DATA  = r_tx_data;
    assign TX_D_VLD   = r_tx_vld;
    assign BUSY       = r_busy;
    assign CMD_ERR    = r_cmd_err;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Bench for rf_cmd_ctrl: frame table, timing corner sequences and random
// frames against a transaction-level reference model.
module tb_rf_cmd_ctrl;

    localparam int RD_TIMEOUT = 4;
    localparam int EV_NONE = 0, EV_WR = 1, EV_RD = 2, EV_TX = 3, EV_ERR = 4;

    logic       clk, rst;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       rf_wr_en, rf_rd_en;
    logic [3:0] rf_addr;
    logic [7:0] rf_wr_data, rf_rd_data;
    logic       rf_rd_valid;
    logic [7:0] tx_data;
    logic       tx_vld, tx_full, busy, cmd_err;

    rf_cmd_ctrl #(.WIDTH(8), .DEPTH(16), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .CLK(clk), .RST(rst),
        .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
        .RF_WrEn(rf_wr_en), .RF_RdEn(rf_rd_en),
        .RF_Address(rf_addr), .RF_WrData(rf_wr_data),
        .RF_RdData(rf_rd_data), .RF_RdData_Valid(rf_rd_valid),
        .TX_P_DATA(tx_data), .TX_D_VLD(tx_vld), .TX_FULL(tx_full),
        .BUSY(busy), .CMD_ERR(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file with one cycle of read latency.
    logic [7:0] rf_mem [16];
    bit         rf_respond;
    always @(posedge clk) begin
        if (rf_wr_en) rf_mem[rf_addr] <= rf_wr_data;
        rf_rd_valid <= rf_rd_en && rf_respond;
        rf_rd_data  <= rf_mem[rf_addr];
    end

    typedef struct {
        int         kind;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;
    ev_t obs_q[$];
    bit  both_hi;

    always @(negedge clk) begin
        if (rf_wr_en) obs_q.push_back('{EV_WR, rf_addr, rf_wr_data});
        if (rf_rd_en) obs_q.push_back('{EV_RD, rf_addr, 8'h00});
        if (tx_vld)   obs_q.push_back('{EV_TX, 4'h0, tx_data});
        if (cmd_err)  obs_q.push_back('{EV_ERR, 4'h0, 8'h00});
        if (rf_wr_en && rf_rd_en) both_hi = 1'b1;
    end

    int ntests = 0;
    int nfail  = 0;
    logic [7:0] ref_mem [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        @(posedge clk);
        #1;
        rx_vld  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int nb, input bit junk);
        send_byte(b0);
        if (nb > 1) begin idle($urandom_range(0, 3)); send_byte(b1); end
        if (nb > 2) begin idle($urandom_range(0, 3)); send_byte(b2); end
        if (junk) send_byte(8'($urandom));
        idle($urandom_range(5, 8));
    endtask

    task automatic expect_ev(input string nm, input int k, input logic [3:0] a, input logic [7:0] d);
        ev_t e;
        int  n = 0;
        while (obs_q.size() == 0 && n < 30) begin idle(1); n++; end
        if (obs_q.size() == 0) begin
            ntests++;
            nfail++;
            $display("FAIL %s: no event within 30 cycles, expected kind %0d", nm, k);
        end else begin
            e = obs_q.pop_front();
            check({nm, " kind"}, e.kind, k);
            if (k == EV_WR || k == EV_RD) check({nm, " addr"}, e.addr, a);
            if (k == EV_WR || k == EV_TX) check({nm, " data"}, e.data, d);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, tx_data, tx_vld, busy, cmd_err};
    endfunction

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         nb;
        int         k1;
        logic [3:0] a;
        logic [7:0] d1;
        int         k2;
        logic [7:0] d2;
    } vec_t;
    vec_t vt[14];

    initial begin
        rst = 1'b1; rx_vld = 1'b0; rx_data = 8'h00; tx_full = 1'b0; rf_respond = 1'b1;
        both_hi = 1'b0;
        #12;
        check("reset outputs", all_outs(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset outputs", all_outs(), 0);

        // Test 1: write 0x3C to address 5
        send_byte(8'hAA);
        check("t1 busy after cmd", busy, 1);
        send_byte(8'h05);
        send_byte(8'h3C);
        check("t1 wren", rf_wr_en, 1);
        check("t1 addr", rf_addr, 5);
        check("t1 wdata", rf_wr_data, 8'h3C);
        idle(1);
        check("t1 wren one cycle", rf_wr_en, 0);
        check("t1 busy drops", busy, 0);
        check("t1 addr held", rf_addr, 5);

        // Test 2: write 0x77 to 7 and read it back with exact latencies
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'h77);
        idle(2);
        send_byte(8'hBB);
        send_byte(8'h07);
        check("t2 rden +1", rf_rd_en, 1);
        check("t2 raddr", rf_addr, 7);
        check("t2 wren low", rf_wr_en, 0);
        idle(1);
        check("t2 rden one cycle", rf_rd_en, 0);
        check("t2 no early tx", tx_vld, 0);
        idle(1);
        check("t2 tx vld +3", tx_vld, 1);
        check("t2 tx data", tx_data, 8'h77);
        idle(1);
        check("t2 tx one cycle", tx_vld, 0);
        check("t2 busy drops", busy, 0);
        obs_q.delete();

        // Frame table
        vt = '{
            '{8'hAA, 8'h03, 8'hC3, 3, EV_WR,  4'h3, 8'hC3, EV_NONE, 8'h00},
            '{8'hBB, 8'h03, 8'h00, 2, EV_RD,  4'h3, 8'h00, EV_TX,   8'hC3},
            '{8'hBB, 8'h05, 8'h00, 2, EV_RD,  4'h5, 8'h00, EV_TX,   8'h3C},
            '{8'h12, 8'h00, 8'h00, 1, EV_ERR, 4'h0, 8'h00, EV_NONE, 8'h00},
            '{8'hAA, 8'h20, 8'h00, 2, EV_ERR, 4'h0, 8'h00, EV_NONE, 8'h00},
            '{8'hBB, 8'h1F, 8'h00, 2, EV_ERR, 4'h0, 8'h00, EV_NONE, 8'h00},
            '{8'hAA, 8'h0F, 8'hFF, 3, EV_WR,  4'hF, 8'hFF, EV_NONE, 8'h00},
            '{8'hBB, 8'h0F, 8'h00, 2, EV_RD,  4'hF, 8'h00, EV_TX,   8'hFF},
            '{8'hAA, 8'h00, 8'h00, 3, EV_WR,  4'h0, 8'h00, EV_NONE, 8'h00},
            '{8'hBB, 8'h00, 8'h00, 2, EV_RD,  4'h0, 8'h00, EV_TX,   8'h00},
            '{8'hAA, 8'h0A, 8'h81, 3, EV_WR,  4'hA, 8'h81, EV_NONE, 8'h00},
            '{8'hBB, 8'h07, 8'h00, 2, EV_RD,  4'h7, 8'h00, EV_TX,   8'h77},
            '{8'hFF, 8'h00, 8'h00, 1, EV_ERR, 4'h0, 8'h00, EV_NONE, 8'h00},
            '{8'h55, 8'h00, 8'h00, 1, EV_ERR, 4'h0, 8'h00, EV_NONE, 8'h00}
        };
        for (int i = 0; i < 14; i++) begin
            send_frame(vt[i].b0, vt[i].b1, vt[i].b2, vt[i].nb, 1'b0);
            expect_ev($sformatf("vec%0d ev1", i), vt[i].k1, vt[i].a, vt[i].d1);
            if (vt[i].k2 != EV_NONE) expect_ev($sformatf("vec%0d ev2", i), vt[i].k2, vt[i].a, vt[i].d2);
            check($sformatf("vec%0d extra events", i), obs_q.size(), 0);
            check($sformatf("vec%0d idle", i), busy, 0);
        end

        // Test 3: read address 2 while the TX FIFO is full
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h5A);
        idle(2);
        tx_full = 1'b1;
        send_byte(8'hBB); send_byte(8'h02);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            check("t3 stall no tx", tx_vld, 0);
            check("t3 stall busy", busy, 1);
        end
        tx_full = 1'b0;
        idle(1);
        check("t3 tx after release", tx_vld, 1);
        check("t3 tx data", tx_data, 8'h5A);
        idle(1);
        check("t3 tx one cycle", tx_vld, 0);
        check("t3 busy drops", busy, 0);

        // Test 4: bad command, bad address, then a normal command
        send_byte(8'h12);
        check("t4 err bad cmd", cmd_err, 1);
        check("t4 no rf strobe", {rf_wr_en, rf_rd_en}, 0);
        check("t4 stays idle", busy, 0);
        idle(1);
        check("t4 err one cycle", cmd_err, 0);
        send_byte(8'hAA);
        send_byte(8'h20);
        check("t4 err bad addr", cmd_err, 1);
        check("t4 back to idle", busy, 0);
        send_byte(8'hBB);
        check("t4 next byte is cmd", busy, 1);
        send_byte(8'h07);
        check("t4 read issued", rf_rd_en, 1);
        idle(2);
        check("t4 read data", tx_data, 8'h77);
        check("t4 read tx vld", tx_vld, 1);
        idle(2);
        obs_q.delete();

        // Test 5: read timeout
        rf_respond = 1'b0;
        begin
            int err_cyc = -1;
            send_byte(8'hBB);
            send_byte(8'h03);
            for (int i = 2; i <= 12; i++) begin
                idle(1);
                if (cmd_err && err_cyc < 0) err_cyc = i;
            end
            check("t5 timeout cycle", err_cyc, 2 + RD_TIMEOUT);
        end
        check("t5 events", obs_q.size(), 2);
        expect_ev("t5 rd", EV_RD, 4'h3, 8'h00);
        expect_ev("t5 err", EV_ERR, 4'h0, 8'h00);
        check("t5 idle", busy, 0);
        rf_respond = 1'b1;

        // Test 6a: reset while waiting for the data byte
        send_byte(8'hAA); send_byte(8'h09);
        #2 rst = 1'b1;
        obs_q.delete();
        #1;
        check("t6a async reset outputs", all_outs(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        idle(6);
        check("t6a no strobe after reset", obs_q.size(), 0);

        // Test 6b: reset during a TX stall
        tx_full = 1'b1;
        send_byte(8'hBB); send_byte(8'h07);
        idle(4);
        check("t6b stalled busy", busy, 1);
        #2 rst = 1'b1;
        obs_q.delete();
        #1;
        check("t6b async reset outputs", all_outs(), 0);
        tx_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        idle(6);
        check("t6b no tx after reset", obs_q.size(), 0);
        send_frame(8'hBB, 8'h07, 8'h00, 2, 1'b0);
        expect_ev("t6b fresh rd", EV_RD, 4'h7, 8'h00);
        expect_ev("t6b fresh tx", EV_TX, 4'h0, 8'h77);

        // Random frames against the transaction-level model
        for (int a = 0; a < 16; a++) begin
            logic [7:0] d = 8'($urandom);
            send_frame(8'hAA, 8'(a), d, 3, 1'b0);
            ref_mem[a] = d;
            expect_ev("rnd init wr", EV_WR, 4'(a), d);
        end
        for (int n = 0; n < 150; n++) begin
            int         r    = $urandom_range(0, 9);
            bit         junk = 1'($urandom_range(0, 1));
            logic [3:0] a    = 4'($urandom);
            logic [7:0] d    = 8'($urandom);
            logic [7:0] b;
            if (r <= 3) begin
                send_frame(8'hAA, {4'h0, a}, d, 3, junk);
                ref_mem[a] = d;
                expect_ev("rnd wr", EV_WR, a, d);
            end else if (r <= 7) begin
                send_frame(8'hBB, {4'h0, a}, 8'h00, 2, junk);
                expect_ev("rnd rd", EV_RD, a, 8'h00);
                expect_ev("rnd tx", EV_TX, 4'h0, ref_mem[a]);
            end else if (r == 8) begin
                do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB);
                send_frame(b, 8'h00, 8'h00, 1, 1'b0);
                expect_ev("rnd bad cmd", EV_ERR, 4'h0, 8'h00);
            end else begin
                b = 8'($urandom_range(16, 255));
                send_frame(junk ? 8'hAA : 8'hBB, b, 8'h00, 2, 1'b0);
                expect_ev("rnd bad addr", EV_ERR, 4'h0, 8'h00);
            end
            check("rnd no extra event", obs_q.size(), 0);
        end

        check("wren and rden never together", both_hi, 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
